// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders; the serial adder ripples
// a chain of these across each slice.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.x(a),  .y(b),   .s(s1),  .c(c1));
    half_adder u_ha1 (.x(s1), .y(cin), .s(sum), .c(c2));

    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB slice first,
// carry held in a register between slices, valid/ready on both ends.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (BITS_PER_CYCLE < 1 || WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]          cnt;
    logic                      carry;
    logic [WIDTH-1:0]          a_r;
    logic [WIDTH-1:0]          b_r;
    logic [BITS_PER_CYCLE-1:0] a_sl;
    logic [BITS_PER_CYCLE-1:0] b_sl;
    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic [BITS_PER_CYCLE:0]   chain;
    logic                      start_hs;
    logic                      done_hs;
    logic                      last;

    assign a_sl     = a_r[cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE];
    assign b_sl     = b_r[cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE];
    assign chain[0] = carry;
    assign last     = (cnt == LAST);
    assign start_hs = start_valid && start_ready;
    assign done_hs  = done_valid && done_ready;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
        full_adder u_fa (
            .a    (a_sl[i]),
            .b    (b_sl[i]),
            .cin  (chain[i]),
            .sum  (slice_sum[i]),
            .cout (chain[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_hs) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done_valid = 1'b1;
                if (done_hs) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand copies are pure data; they are only read after being loaded.
    always_ff @(posedge clk) begin
        if (state == IDLE && start_hs) begin
            a_r <= a;
            b_r <= (mode == MODE_SUB) ? ~b : b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_hs) begin
                        carry <= (mode == MODE_ADD) ? cin : 1'b1;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum[cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE] <= slice_sum;
                    carry <= chain[BITS_PER_CYCLE];
                    if (last) begin
                        cnt      <= '0;
                        cout     <= chain[BITS_PER_CYCLE];
                        overflow <= chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one 1-bit-per-cycle and one 4-bit-per-cycle instance
// share inputs; a scoreboard holds expected results until each done handshake.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic       clk;
    logic       rst;
    logic       start_valid;
    logic       done_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mode;

    logic       start_ready1, cout1, ovf1, done_valid1, busy1;
    logic [7:0] sum1;
    logic       start_ready4, cout4, ovf4, done_valid4, busy4;
    logic [7:0] sum4;

    int   errors = 0;
    int   checks = 0;
    res_t sb[$];

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready1),
        .a(a), .b(b), .cin(cin), .mode(mode), .sum(sum1), .cout(cout1),
        .overflow(ovf1), .done_valid(done_valid1), .done_ready(done_ready), .busy(busy1)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready4),
        .a(a), .b(b), .cin(cin), .mode(mode), .sum(sum4), .cout(cout4),
        .overflow(ovf4), .done_valid(done_valid4), .done_ready(done_ready), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] ia, input logic [7:0] ib,
                                   input logic ic, input logic im);
        logic [7:0] bb;
        logic       c0;
        logic [8:0] r;
        res_t       e;
        bb     = im ? ~ib : ib;
        c0     = im ? 1'b1 : ic;
        r      = {1'b0, ia} + {1'b0, bb} + {8'd0, c0};
        e.sum  = r[7:0];
        e.cout = r[8];
        e.ovf  = (ia[7] == bb[7]) && (r[7] != ia[7]);
        return e;
    endfunction

    task automatic check_outputs(input string tag, input res_t e);
        check_val({tag, "_sum1"},  32'(sum1),  32'(e.sum));
        check_val({tag, "_cout1"}, 32'(cout1), 32'(e.cout));
        check_val({tag, "_ovf1"},  32'(ovf1),  32'(e.ovf));
        check_val({tag, "_sum4"},  32'(sum4),  32'(e.sum));
        check_val({tag, "_cout4"}, 32'(cout4), 32'(e.cout));
        check_val({tag, "_ovf4"},  32'(ovf4),  32'(e.ovf));
    endtask

    // hold: cycles of done_ready=0 after done_valid; pend: request a start meanwhile
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic im, input int hold, input bit pend);
        res_t e;
        int   n;
        int   lat;
        int   lat4;
        a = ia; b = ib; cin = ic; mode = im; start_valid = 1'b1;
        n = 0;
        while (!start_ready1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("start_ready_pre",  32'(start_ready1), 32'd1);
        check_val("start_ready4_pre", 32'(start_ready4), 32'd1);
        sb.push_back(model(ia, ib, ic, im));
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); mode = 1'($urandom);
        check_val("start_ready_busy", 32'(start_ready1), 32'd0);
        check_val("busy_run",         32'(busy1),        32'd1);
        lat  = 0;
        lat4 = -1;
        while (!done_valid1 && lat < 40) begin
            if (done_valid4 && lat4 < 0) lat4 = lat;
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency",  32'(lat),  32'd8);
        check_val("latency4", 32'(lat4), 32'd2);
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check_outputs("done", e);
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                start_valid = 1'b1;
                a = 8'h3C; b = 8'hC3;
            end
            @(posedge clk); #1;
            check_val("hold_start_ready", 32'(start_ready1), 32'd0);
            check_val("hold_done_valid",  32'(done_valid1),  32'd1);
            check_outputs("hold", e);
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check_val("post_done_valid1", 32'(done_valid1), 32'd0);
        check_val("post_done_valid4", 32'(done_valid4), 32'd0);
        check_val("post_busy",        32'(busy1),       32'd0);
        check_outputs("post", e);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; mode = 1'b0;
        #1;
        check_val("rst_start_ready", 32'(start_ready1), 32'd1);
        check_val("rst_busy",        32'(busy1),        32'd0);
        check_val("rst_done_valid",  32'(done_valid1),  32'd0);
        check_outputs("rst", '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'hFE, 8'h01, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 5, 1'b1);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0, 1'b0);

        // abort in the third RUN cycle
        a = 8'h55; b = 8'h11; cin = 1'b0; mode = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check_val("abort_busy",        32'(busy1),        32'd0);
        check_val("abort_start_ready", 32'(start_ready1), 32'd1);
        check_val("abort_done_valid",  32'(done_valid1),  32'd0);
        check_outputs("abort", '0);
        #2 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_valid1) seen++;
        end
        check_val("abort_no_done", 32'(seen), 32'd0);

        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), i % 3, 1'b0);
        end
        check_val("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
